// File: rtl/street_sensor_cond.sv
// street_sensor_cond: synchronise, debounce and queue-count main/cross vehicle sensors for the light FSMs
module street_sensor_cond #(
    parameter int DEBOUNCE  = 3,
    parameter int DRAIN_CYC = 2,
    parameter int MAX_CARS  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_main,
    input  logic       sensor_cross,
    input  logic [4:0] state_main,
    input  logic [4:0] state_cross,
    output logic       waiting,
    output logic       waiting_cross,
    output logic [3:0] count_main,
    output logic [3:0] count_cross,
    output logic       ovf_main,
    output logic       ovf_cross
);
    logic [1:0]      sens, green, ovf_v;
    logic [1:0][3:0] cnt_v;
    assign sens  = {sensor_cross, sensor_main};
    assign green = {state_cross == 5'b10000, state_main == 5'b10000};
    genvar c;
    for (c = 0; c < 2; c++) begin : g_ch
        logic       s1, s2, filt, ovf, arr, dep;
        logic [3:0] deb, tmr, count;
        assign arr = s2 && !filt && deb == 4'(DEBOUNCE - 1);
        assign dep = green[c] && count != 4'd0 && tmr == 4'(DRAIN_CYC - 1);
        always_ff @(posedge clk) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                filt  <= 1'b0;
                deb   <= 4'd0;
                tmr   <= 4'd0;
                count <= 4'd0;
                ovf   <= 1'b0;
            end else begin
                s1 <= sens[c];
                s2 <= s1;
                if (s2 == filt) deb <= 4'd0;
                else if (deb == 4'(DEBOUNCE - 1)) begin
                    filt <= s2;
                    deb  <= 4'd0;
                end else deb <= deb + 4'd1;
                tmr <= (!green[c] || count == 4'd0 || dep) ? 4'd0 : tmr + 4'd1;
                // a simultaneous arrival and departure cancel, leaving count and ovf untouched
                if (arr && !dep) begin
                    if (count < 4'(MAX_CARS)) count <= count + 4'd1;
                    else ovf <= 1'b1;
                end else if (dep && !arr) count <= count - 4'd1;
            end
        end
        assign cnt_v[c] = count;
        assign ovf_v[c] = ovf;
    end
    assign count_main    = cnt_v[0];
    assign count_cross   = cnt_v[1];
    assign ovf_main      = ovf_v[0];
    assign ovf_cross     = ovf_v[1];
    assign waiting       = |count_main;
    assign waiting_cross = |count_cross;
endmodule

// File: tb/tb_street_sensor_cond.sv
// tb_street_sensor_cond: directed scenarios for the sensor conditioner with hand-computed expectations
module tb_street_sensor_cond;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_main = 1'b0, sensor_cross = 1'b0;
    logic [4:0] state_main = 5'b00001, state_cross = 5'b00001;
    logic       waiting, waiting_cross, ovf_main, ovf_cross;
    logic [3:0] count_main, count_cross;
    int         tests = 0, fails = 0;

    street_sensor_cond dut (
        .clk(clk), .rst(rst),
        .sensor_main(sensor_main), .sensor_cross(sensor_cross),
        .state_main(state_main), .state_cross(state_cross),
        .waiting(waiting), .waiting_cross(waiting_cross),
        .count_main(count_main), .count_cross(count_cross),
        .ovf_main(ovf_main), .ovf_cross(ovf_cross)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one clean arrival: high long enough to pass debounce, low long enough for filt to fall
    task automatic pulse(input bit ch);
        if (ch) sensor_cross = 1'b1; else sensor_main = 1'b1;
        repeat (5) tick();
        if (ch) sensor_cross = 1'b0; else sensor_main = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if ({count_main, count_cross} !== 8'h00) begin
            fails++; $display("FAIL reset_counts got %h want 00", {count_main, count_cross});
        end
        tests++;
        if ({waiting, waiting_cross, ovf_main, ovf_cross} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {waiting, waiting_cross, ovf_main, ovf_cross});
        end
        rst = 1'b0;
    endtask

    task automatic test_arrival();
        sensor_main = 1'b1;
        repeat (4) tick();
        tests++;
        if (count_main !== 4'd0) begin
            fails++; $display("FAIL arrival_edge3 got %0d want 0", count_main);
        end
        tick();
        tests++;
        if (count_main !== 4'd1 || waiting !== 1'b1) begin
            fails++; $display("FAIL arrival_edge4 got count=%0d waiting=%b want 1/1", count_main, waiting);
        end
        repeat (5) tick();
        sensor_main = 1'b0;
        repeat (8) tick();
        tests++;
        if (count_main !== 4'd1 || count_cross !== 4'd0 || waiting_cross !== 1'b0) begin
            fails++; $display("FAIL arrival_hold got main=%0d cross=%0d wc=%b want 1/0/0", count_main, count_cross, waiting_cross);
        end
    endtask

    task automatic test_glitch();
        sensor_cross = 1'b1;
        repeat (2) tick();
        sensor_cross = 1'b0;
        repeat (8) tick();
        tests++;
        if (count_cross !== 4'd0 || waiting_cross !== 1'b0) begin
            fails++; $display("FAIL glitch_2cyc got %0d want 0", count_cross);
        end
        sensor_cross = 1'b1;
        repeat (3) tick();
        sensor_cross = 1'b0;
        repeat (8) tick();
        tests++;
        if (count_cross !== 4'd1 || waiting_cross !== 1'b1) begin
            fails++; $display("FAIL glitch_3cyc got %0d want 1", count_cross);
        end
    endtask

    task automatic test_drain();
        logic [3:0] exp_cnt [6] = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        pulse(1'b0);
        pulse(1'b0);
        tests++;
        if (count_main !== 4'd3) begin
            fails++; $display("FAIL drain_setup got %0d want 3", count_main);
        end
        state_main = 5'b10000;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (count_main !== exp_cnt[i]) begin
                fails++; $display("FAIL drain_edge%0d got %0d want %0d", i + 1, count_main, exp_cnt[i]);
            end
        end
        tests++;
        if (waiting !== 1'b0) begin
            fails++; $display("FAIL drain_waiting got %b want 0", waiting);
        end
        repeat (4) tick();
        tests++;
        if (count_main !== 4'd0) begin
            fails++; $display("FAIL drain_idle got %0d want 0", count_main);
        end
        state_main = 5'b00001;
    endtask

    task automatic test_back_to_back();
        pulse(1'b0);
        pulse(1'b0);
        sensor_main = 1'b1;
        repeat (3) tick();
        state_main = 5'b10000;
        tick();
        tests++;
        if (count_main !== 4'd2) begin
            fails++; $display("FAIL b2b_pre got %0d want 2", count_main);
        end
        tick();
        tests++;
        if (count_main !== 4'd2) begin
            fails++; $display("FAIL b2b_coincide got %0d want 2", count_main);
        end
        sensor_main = 1'b0;
        repeat (2) tick();
        tests++;
        if (count_main !== 4'd1) begin
            fails++; $display("FAIL b2b_next_dep got %0d want 1", count_main);
        end
        repeat (6) tick();
        tests++;
        if (count_main !== 4'd0) begin
            fails++; $display("FAIL b2b_empty got %0d want 0", count_main);
        end
        state_main = 5'b00001;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 15; i++) pulse(1'b0);
        tests++;
        if (count_main !== 4'd15 || ovf_main !== 1'b0) begin
            fails++; $display("FAIL ovf_15 got count=%0d ovf=%b want 15/0", count_main, ovf_main);
        end
        sensor_main = 1'b1;
        repeat (4) tick();
        tests++;
        if (ovf_main !== 1'b0) begin
            fails++; $display("FAIL ovf_edge3 got %b want 0", ovf_main);
        end
        tick();
        tests++;
        if (count_main !== 4'd15 || ovf_main !== 1'b1 || ovf_cross !== 1'b0) begin
            fails++; $display("FAIL ovf_16 got count=%0d ovf=%b ovfc=%b want 15/1/0", count_main, ovf_main, ovf_cross);
        end
        sensor_main = 1'b0;
        state_main = 5'b10000;
        repeat (40) tick();
        tests++;
        if (count_main !== 4'd0 || ovf_main !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky got count=%0d ovf=%b want 0/1", count_main, ovf_main);
        end
        state_main = 5'b11000;
        pulse(1'b0);
        repeat (6) tick();
        tests++;
        if (count_main !== 4'd1) begin
            fails++; $display("FAIL non_onehot_green got %0d want 1", count_main);
        end
        state_main = 5'b00001;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) pulse(1'b1);
        tests++;
        if (count_cross !== 4'd5) begin
            fails++; $display("FAIL rstmid_setup got %0d want 5", count_cross);
        end
        sensor_cross = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({count_main, count_cross} !== 8'h00 || {waiting, waiting_cross, ovf_main, ovf_cross} !== 4'b0000) begin
            fails++; $display("FAIL rstmid_clear got counts=%h flags=%b want 00/0000", {count_main, count_cross}, {waiting, waiting_cross, ovf_main, ovf_cross});
        end
        repeat (4) tick();
        tests++;
        if (count_cross !== 4'd0) begin
            fails++; $display("FAIL rstmid_early got %0d want 0", count_cross);
        end
        tick();
        tests++;
        if (count_cross !== 4'd1) begin
            fails++; $display("FAIL rstmid_rearrive got %0d want 1", count_cross);
        end
        sensor_cross = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arrival();
        test_glitch();
        test_drain();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
